// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the fetch-address generator
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HOLD
  } pc_state_e;

  // log2 of the fetch step (1..8 bytes); used to size the alignment check
  function automatic int inst_shift(input int bytes);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if ((1 << i) < bytes) s = i + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-pc / next-state priority selector
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = 4
) (
  input  pc_state_e         state,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pending,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  output pc_state_e         state_d,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pending_d
);

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pending_d = pending;
    if (state == PC_BOOT) begin
      // first fetch happens at the reset vector, so the pc is not advanced here
      state_d = PC_RUN;
    end else if (flush_i) begin
      pc_d      = flush_target_i;
      pending_d = '0;
      state_d   = PC_RUN;
    end else if (stall_i) begin
      if (br_valid_i) begin
        pending_d = br_target_i;
        state_d   = PC_HOLD;
      end
    end else if (br_valid_i) begin
      pc_d      = br_target_i;
      pending_d = '0;
      state_d   = PC_RUN;
    end else if (state == PC_HOLD) begin
      pc_d      = pending;
      pending_d = '0;
      state_d   = PC_RUN;
    end else begin
      pc_d = pc + ADDR_W'(INST_BYTES);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with stall, branch buffering and flush; optional PC_ALIGN_CHECK_EN adds misalign_o
module pc_gen
  import pc_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int          INST_BYTES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              redir_pending_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VECTOR);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pending_q, pending_d;

  pc_next_sel #(
    .ADDR_W    (ADDR_W),
    .INST_BYTES(INST_BYTES)
  ) u_next_sel (
    .state         (state_q),
    .pc            (pc_q),
    .pending       (pending_q),
    .stall_i       (stall_i),
    .br_valid_i    (br_valid_i),
    .br_target_i   (br_target_i),
    .flush_i       (flush_i),
    .flush_target_i(flush_target_i),
    .state_d       (state_d),
    .pc_d          (pc_d),
    .pending_d     (pending_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PC_BOOT;
      pc_q      <= RV;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

  assign pc_o            = pc_q;
  assign ce_o            = (state_q != PC_BOOT);
  assign redir_pending_o = (state_q == PC_HOLD);

`ifdef PC_ALIGN_CHECK_EN
  localparam int                ALIGN_BITS = inst_shift(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_BITS) - 1);

  // flag is computed from the next pc so it lines up with pc_o
  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= |(pc_d & ALIGN_MASK);
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen with a rule-level reference model
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_valid_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_target_i = '0;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        redir_pending_o;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .br_valid_i     (br_valid_i),
    .br_target_i    (br_target_i),
    .flush_i        (flush_i),
    .flush_target_i (flush_target_i),
    .pc_o           (pc_o),
    .ce_o           (ce_o),
    .redir_pending_o(redir_pending_o)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // reference model: fetching flag, expected pc, and an optional buffered target
  bit          m_valid = 0;
  bit          m_fetching;
  bit          m_has_pend;
  logic [31:0] m_pc;
  logic [31:0] m_pend;

  always @(posedge clk) begin
    m_valid = 1;
    if (rst) begin
      m_pc       = 32'hBFC0_0000;
      m_fetching = 0;
      m_has_pend = 0;
    end else if (!m_fetching) begin
      m_fetching = 1;
    end else if (flush_i) begin
      m_pc       = flush_target_i;
      m_has_pend = 0;
    end else if (stall_i) begin
      if (br_valid_i) begin
        m_pend     = br_target_i;
        m_has_pend = 1;
      end
    end else if (br_valid_i) begin
      m_pc       = br_target_i;
      m_has_pend = 0;
    end else if (m_has_pend) begin
      m_pc       = m_pend;
      m_has_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (pc_o !== m_pc || ce_o !== m_fetching || redir_pending_o !== m_has_pend) begin
        errors++;
        $display("FAIL model t=%0t pc=%h/%h ce=%b/%b pend=%b/%b (actual/required)",
                 $time, pc_o, m_pc, ce_o, m_fetching, redir_pending_o, m_has_pend);
      end
`ifdef PC_ALIGN_CHECK_EN
      checks++;
      if (misalign_o !== (m_pc[1:0] != 2'b00)) begin
        errors++;
        $display("FAIL model_misalign t=%0t actual=%b required=%b",
                 $time, misalign_o, (m_pc[1:0] != 2'b00));
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic b, input logic [31:0] bt,
                     input logic f, input logic [31:0] ft);
    stall_i        = s;
    br_valid_i     = b;
    br_target_i    = bt;
    flush_i        = f;
    flush_target_i = ft;
    @(posedge clk);
    #1;
  endtask

  task automatic run1();
    cyc(0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    repeat (3) run1();
    chk("reset_ce", {31'b0, ce_o}, 32'd0);
    chk("reset_pc", pc_o, 32'hBFC0_0000);
    chk("reset_pend", {31'b0, redir_pending_o}, 32'd0);

    rst = 1'b0;
    run1();
    chk("boot_ce", {31'b0, ce_o}, 32'd1);
    chk("boot_pc", pc_o, 32'hBFC0_0000);
    run1();
    chk("seq1", pc_o, 32'hBFC0_0004);
    run1();
    chk("seq2", pc_o, 32'hBFC0_0008);
    run1();
    run1();
    chk("seq4", pc_o, 32'hBFC0_0010);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h0, 0, 32'h0);
      chk("stall_pc", pc_o, 32'hBFC0_0010);
      chk("stall_ce", {31'b0, ce_o}, 32'd1);
    end
    run1();
    chk("stall_release", pc_o, 32'hBFC0_0014);

    cyc(1, 1, 32'h8000_1000, 0, 32'h0);
    chk("hold_pend", {31'b0, redir_pending_o}, 32'd1);
    chk("hold_pc", pc_o, 32'hBFC0_0014);
    cyc(1, 0, 32'h0, 0, 32'h0);
    cyc(1, 1, 32'h8000_2000, 0, 32'h0);
    chk("hold_pc2", pc_o, 32'hBFC0_0014);
    run1();
    chk("hold_release_pc", pc_o, 32'h8000_2000);
    chk("hold_release_pend", {31'b0, redir_pending_o}, 32'd0);
    run1();
    chk("after_hold_seq", pc_o, 32'h8000_2004);

    cyc(1, 1, 32'h8000_3000, 0, 32'h0);
    cyc(1, 1, 32'h8000_4000, 1, 32'h8000_0180);
    chk("flush_pc", pc_o, 32'h8000_0180);
    chk("flush_pend", {31'b0, redir_pending_o}, 32'd0);
    cyc(1, 0, 32'h0, 0, 32'h0);
    chk("flush_stalled", pc_o, 32'h8000_0180);
    run1();
    chk("flush_seq", pc_o, 32'h8000_0184);

    cyc(1, 1, 32'h8000_5000, 0, 32'h0);
    cyc(0, 1, 32'h8000_6000, 0, 32'h0);
    chk("hold_newbr_pc", pc_o, 32'h8000_6000);
    chk("hold_newbr_pend", {31'b0, redir_pending_o}, 32'd0);

    cyc(0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    chk("wrap_top", pc_o, 32'hFFFF_FFFC);
    run1();
    chk("wrap_zero", pc_o, 32'h0000_0000);
    run1();
    chk("wrap_four", pc_o, 32'h0000_0004);

    cyc(1, 1, 32'h8000_7000, 0, 32'h0);
    chk("rst_hold_pend", {31'b0, redir_pending_o}, 32'd1);
    rst = 1'b1;
    cyc(1, 1, 32'h8000_7100, 0, 32'h0);
    chk("rst_hold_pc", pc_o, 32'hBFC0_0000);
    chk("rst_hold_ce", {31'b0, ce_o}, 32'd0);
    chk("rst_hold_clear", {31'b0, redir_pending_o}, 32'd0);
    rst = 1'b0;
    cyc(1, 1, 32'h8000_8000, 1, 32'h8000_9000);
    chk("boot_ignore_pc", pc_o, 32'hBFC0_0000);
    chk("boot_ignore_pend", {31'b0, redir_pending_o}, 32'd0);
    run1();
    chk("boot_ignore_seq", pc_o, 32'hBFC0_0004);

    cyc(0, 1, 32'h8000_0002, 0, 32'h0);
    chk("mis_pc", pc_o, 32'h8000_0002);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_flag", {31'b0, misalign_o}, 32'd1);
`endif
    run1();
    chk("mis_seq_pc", pc_o, 32'h8000_0006);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_seq_flag", {31'b0, misalign_o}, 32'd1);
`endif
    cyc(0, 1, 32'h8000_0000, 0, 32'h0);
    chk("mis_clear_pc", pc_o, 32'h8000_0000);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_clear_flag", {31'b0, misalign_o}, 32'd0);
`endif
    run1();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator; next generation of the instruction PC register.
- Sits at the head of the fetch stage and drives the instruction-memory address and chip-enable.
- Adds the following over a plain incrementing PC:
  - configurable reset vector, width and step;
  - stall hold;
  - branch redirect, with a branch arriving during a stall buffered;
  - exception/flush redirect;
  - explicit start-up state machine.

Parameters:
- ADDR_W, 32, width of PC in bits.
- RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset (truncated to ADDR_W).
- INST_BYTES, 4, PC increment per sequential fetch; power of two, 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  fetch cannot accept; hold pc_o.
- br_valid_i  in  1  branch/jump redirect request, one-cycle pulse.
- br_target_i  in  ADDR_W  branch target.
- flush_i  in  1  exception/eret flush, one-cycle pulse.
- flush_target_i  in  ADDR_W  exception handler or EPC target.
- pc_o  out  ADDR_W  current fetch address.
- ce_o  out  1  instruction memory chip enable.
- redir_pending_o  out  1  a branch target is buffered awaiting stall release.

Behaviour:
- Reset is synchronous, active-high, clock clk. While rst=1 at a rising edge:
  - pc_o=RESET_VECTOR, ce_o=0, redir_pending_o=0, state=BOOT.
- States:
  - BOOT: first edge with rst=0 -> RUN, ce_o<=1, pc_o unchanged, so the first fetch is at RESET_VECTOR.
  - RUN: normal fetch.
  - HOLD: stalled with a buffered branch target.
- Next-PC priority per edge (state RUN/HOLD), highest first:
  1. flush_i: pc_o<=flush_target_i, regardless of stall; clears pending; state->RUN.
  2. stall_i=1:
     - pc_o held.
     - If br_valid_i, capture br_target_i into pending, redir_pending_o<=1, state->HOLD.
     - A later branch while in HOLD overwrites pending (last wins).
  3. stall_i=0 with br_valid_i: pc_o<=br_target_i. This also applies in HOLD: the new branch wins and pending is cleared.
  4. stall_i=0 in HOLD, no branch: pc_o<=pending, clear pending, state->RUN.
  5. stall_i=0 in RUN: pc_o<=pc_o+INST_BYTES, modulo 2^ADDR_W (wrap all-ones region to 0, no flag).
- In BOOT, flush_i, br_valid_i and stall_i are ignored.
- Latency:
  - Redirect visible on pc_o the cycle after the request edge.
  - Buffered redirect visible the cycle after stall_i drops.
- ce_o stays 1 in RUN/HOLD; stall does not drop it.
- rst asserted mid-stall or mid-HOLD discards pending and returns to BOOT.
- Targets are not aligned or modified by the block.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0), registered, 1 in any cycle where pc_o[log2(INST_BYTES)-1:0]!=0.
  - The block still fetches the misaligned address; exception handling is owned downstream.
- Undefined: port absent, no check logic.

Decomposition:
- Package pc_pkg:
  - pc_state_e enum {PC_BOOT, PC_RUN, PC_HOLD};
  - localparam helper for log2(INST_BYTES).
- Sub-module pc_next_sel: combinational priority mux computing next pc/state/pending from the inputs above. The top file holds the registers only.

Test Plan:
- Reset/boot: rst=1 for 3 cycles then 0 -> ce_o=0 during reset; next edge ce_o=1, pc_o=BFC00000; following edges BFC00004, BFC00008.
- Stall hold: stall_i=1 for 4 cycles at pc BFC00010 -> pc_o stays BFC00010, ce_o=1; release -> BFC00014.
- Branch during stall: stall_i=1, br_valid_i pulse target 80001000, then br_valid_i pulse target 80002000 while still stalled -> redir_pending_o=1, pc_o held; stall_i drops -> pc_o=80002000, redir_pending_o=0.
- Flush overrides all: flush_i with target 80000180 coincident with stall_i=1, br_valid_i=1 and a pending target -> pc_o=80000180 next cycle, redir_pending_o=0, then increments once stall clears.
- Wrap/reset mid-HOLD: redirect to FFFFFFFC, run -> 00000000. Separately, assert rst while in HOLD -> pending cleared, ce_o=0, pc_o=BFC00000.
- With PC_ALIGN_CHECK_EN: branch to 80000002 -> misalign_o=1 while pc_o=80000002; next sequential 80000006 still flagged; redirect to 80000000 clears it.
